pkt_arbiter: RTL and testbench

PKT_ARBITER -- requirements
Module: pkt_arbiter

---
 rtl/pkt_arb_pkg.sv | 19 +
 rtl/pkt_arb_rr.sv | 23 ++
 rtl/pkt_arbiter.sv | 154 +++++++++++++++
 tb/tb_pkt_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types for the two-requester packet arbiter: FSM states, owner index, length limits.
package pkt_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PKT   = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    typedef logic owner_t;

    localparam int unsigned MAX_LEN_DEF = 16;
    localparam int unsigned CNT_W       = 8;

    function automatic logic [1:0] owner_onehot(input owner_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pkt_arb_rr.sv
// Two-way round-robin picker; purely combinational, zero latency, no backpressure.
// On a tie the requester that did not own the channel last time wins.
module pkt_arb_rr
    import pkt_arb_pkg::*;
(
    input  logic [1:0] i_eligible,
    input  owner_t     i_last_owner,
    output logic       o_win_vld,
    output owner_t     o_win_idx
);

    always_comb begin
        o_win_vld = |i_eligible;
        o_win_idx = 1'b0;
        unique case (i_eligible)
            2'b01:   o_win_idx = 1'b0;
            2'b10:   o_win_idx = 1'b1;
            2'b11:   o_win_idx = ~i_last_owner;
            default: o_win_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/pkt_arbiter.sv
// Packet-atomic arbiter of two requesters onto one registered output channel.
// Latency: head seen in IDLE -> out_valid 2 cycles, later beats 1 cycle; owner stalls while output beat unaccepted.
module pkt_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_head,
    input  logic [1:0]        req_tail,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic              out_valid,
    output logic              out_head,
    output logic              out_tail,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        grant,
    output logic              err_len
);

    localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t         r_state;
    owner_t             r_owner;
    owner_t             r_last_owner;
    logic [1:0]         r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic               r_out_head;
    logic               r_out_tail;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_err_len;

    logic [1:0]         w_eligible;
    logic               w_win_vld;
    owner_t             w_win_idx;
    logic               w_out_free;
    logic [1:0]         w_ready;
    logic               w_own_vld;
    logic               w_own_tail;
    logic [DATA_W-1:0]  w_own_data;
    logic               w_pkt_acc;
    logic               w_drain_acc;
    logic               w_len_hit;
    logic               w_cnt_sat;

    assign w_eligible = req_valid & req_head;

    pkt_arb_rr u_rr (
        .i_eligible   (w_eligible),
        .i_last_owner (r_last_owner),
        .o_win_vld    (w_win_vld),
        .o_win_idx    (w_win_idx)
    );

    assign w_out_free = ~r_out_valid | out_ready;
    assign w_own_vld  = req_valid[r_owner];
    assign w_own_tail = req_tail[r_owner];
    assign w_own_data = r_owner ? req_data1 : req_data0;
    assign w_len_hit  = (r_cnt == LEN_LAST);
    assign w_cnt_sat  = (r_cnt == '1);

    // Heads are held off in IDLE so the winner's head is taken once it owns the channel.
    always_comb begin
        w_ready = '0;
        unique case (r_state)
            ARB_IDLE:  w_ready = req_valid & ~req_head;
            ARB_PKT:   w_ready[r_owner] = w_out_free;
            ARB_DRAIN: w_ready[r_owner] = 1'b1;
            default:   w_ready = '0;
        endcase
    end

    assign w_pkt_acc   = (r_state == ARB_PKT) & w_own_vld & w_out_free;
    assign w_drain_acc = (r_state == ARB_DRAIN) & w_own_vld;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ARB_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_head   <= 1'b0;
            r_out_tail   <= 1'b0;
            r_out_data   <= '0;
            r_err_len    <= 1'b0;
        end else begin
            r_err_len <= 1'b0;
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_win_vld) begin
                        r_owner <= w_win_idx;
                        r_grant <= owner_onehot(w_win_idx);
                        r_cnt   <= '0;
                        r_state <= ARB_PKT;
                    end
                end
                ARB_PKT: begin
                    if (w_pkt_acc) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_own_data;
                        r_out_head  <= (r_cnt == '0);
                        r_out_tail  <= w_own_tail | w_len_hit;
                        if (!w_cnt_sat) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                        if (w_own_tail) begin
                            r_state      <= ARB_IDLE;
                            r_last_owner <= r_owner;
                            r_grant      <= '0;
                        end else if (w_len_hit) begin
                            r_err_len <= 1'b1;
                            r_state   <= ARB_DRAIN;
                        end
                    end
                end
                ARB_DRAIN: begin
                    if (w_drain_acc) begin
                        if (!w_cnt_sat) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                        if (w_own_tail) begin
                            r_state      <= ARB_IDLE;
                            r_last_owner <= r_owner;
                            r_grant      <= '0;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // Ready is combinational, so it is gated to stay low while reset is held.
    assign req_ready = w_ready & {2{reset_n}};
    assign out_valid = r_out_valid;
    assign out_head  = r_out_head;
    assign out_tail  = r_out_tail;
    assign out_data  = r_out_data;
    assign grant     = r_grant;
    assign err_len   = r_err_len;

endmodule

// File: tb/tb_pkt_arbiter.sv
// Directed bench for pkt_arbiter (MAX_LEN=4): expected output beats queued as stimulus is
// issued and compared as the channel hands them off; framing, grant and reset checked inline.
module tb_pkt_arbiter;

    typedef struct packed {
        logic [7:0] d;
        logic       h;
        logic       t;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       v0, h0, t0, v1, h1, t1;
    logic [7:0] d0, d1;
    logic       out_ready;
    logic [1:0] req_valid, req_head, req_tail, req_ready, grant;
    logic       out_valid, out_head, out_tail, err_len;
    logic [7:0] out_data;

    int    checks = 0;
    int    errors = 0;
    int    g0_cycles = 0;
    int    err_cnt = 0;
    int    r1_bad = 0;
    beat_t exp_q[$];

    assign req_valid = {v1, v0};
    assign req_head  = {h1, h0};
    assign req_tail  = {t1, t0};

    always #5 clk = ~clk;

    pkt_arbiter #(.DATA_W(8), .MAX_LEN(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_head  (req_head),
        .req_tail  (req_tail),
        .req_data0 (d0),
        .req_data1 (d1),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_head  (out_head),
        .out_tail  (out_tail),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .err_len   (err_len)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic h, input logic t);
        exp_q.push_back('{d: d, h: h, t: t});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_ovld"}, 32'(out_valid), 32'h0);
        chk({tag, "_ohead"}, 32'(out_head), 32'h0);
        chk({tag, "_otail"}, 32'(out_tail), 32'h0);
        chk({tag, "_odata"}, 32'(out_data), 32'h0);
        chk({tag, "_err"}, 32'(err_len), 32'h0);
    endtask

    // Present one beat on requester r and hold it until the arbiter takes it.
    task automatic send(input int r, input logic [7:0] d, input logic h, input logic t);
        int n;
        if (r == 0) begin v0 = 1'b1; h0 = h; t0 = t; d0 = d; end
        else        begin v1 = 1'b1; h1 = h; t1 = t; d1 = d; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[r] && n < 50);
        chk("accept_wait", 32'(n < 50), 32'h1);
        @(posedge clk);
        #1;
        if (r == 0) begin v0 = 1'b0; h0 = 1'b0; t0 = 1'b0; end
        else        begin v1 = 1'b0; h1 = 1'b0; t1 = 1'b0; end
    endtask

    task automatic monitor();
        beat_t      e;
        logic       p_vld = 1'b0;
        logic       p_rdy = 1'b0;
        logic       p_h = 1'b0;
        logic       p_t = 1'b0;
        logic [7:0] p_dat = 8'h0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                p_vld = 1'b0;
            end else begin
                if (grant == 2'b01) g0_cycles++;
                if (err_len) err_cnt++;
                if (grant == 2'b01 && req_ready[1]) r1_bad++;
                if (p_vld && !p_rdy) begin
                    chk("hold_vld", 32'(out_valid), 32'h1);
                    chk("hold_data", 32'(out_data), 32'(p_dat));
                    chk("hold_head", 32'(out_head), 32'(p_h));
                    chk("hold_tail", 32'(out_tail), 32'(p_t));
                end
                if (out_valid && out_ready) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL sb_extra got %0h exp none", out_data);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("sb_data", 32'(out_data), 32'(e.d));
                        chk("sb_head", 32'(out_head), 32'(e.h));
                        chk("sb_tail", 32'(out_tail), 32'(e.t));
                    end
                end
                p_vld = out_valid;
                p_rdy = out_ready;
                p_dat = out_data;
                p_h   = out_head;
                p_t   = out_tail;
            end
        end
    endtask

    initial begin
        int g0_start, err_start, r1_start;
        v0 = 1'b0; h0 = 1'b0; t0 = 1'b0; d0 = 8'h0;
        v1 = 1'b0; h1 = 1'b0; t1 = 1'b0; d1 = 8'h0;
        out_ready = 1'b1;
        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog got timeout exp finish");
                $fatal(1, "timeout");
            end
        join_none

        // Reset: ready must stay low even with headless beats presented.
        #2 reset_n = 1'b0;
        v0 = 1'b1; v1 = 1'b1;
        #1 chk_zero("rst");
        repeat (2) @(posedge clk);
        #1 v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 3-beat packet on requester 0.
        push(8'hA1, 1'b1, 1'b0); push(8'hA2, 1'b0, 1'b0); push(8'hA3, 1'b0, 1'b1);
        g0_start = g0_cycles;
        send(0, 8'hA1, 1'b1, 1'b0);
        chk("a_lat_vld", 32'(out_valid), 32'h1);
        chk("a_lat_head", 32'(out_head), 32'h1);
        chk("a_grant", 32'(grant), 32'h1);
        send(0, 8'hA2, 1'b0, 1'b0);
        send(0, 8'hA3, 1'b0, 1'b1);
        chk("a_grant_clr", 32'(grant), 32'h0);
        chk("a_grant_cycles", 32'(g0_cycles - g0_start), 32'd3);

        // Overlength packet on requester 1: beat 4 closes it, beats 5-6 dropped.
        push(8'hE0, 1'b1, 1'b0); push(8'hE1, 1'b0, 1'b0);
        push(8'hE2, 1'b0, 1'b0); push(8'hE3, 1'b0, 1'b1);
        err_start = err_cnt;
        send(1, 8'hE0, 1'b1, 1'b0);
        send(1, 8'hE1, 1'b0, 1'b0);
        send(1, 8'hE2, 1'b0, 1'b0);
        send(1, 8'hE3, 1'b0, 1'b0);
        chk("e_err_pulse", 32'(err_len), 32'h1);
        chk("e_forced_tail", 32'(out_tail), 32'h1);
        chk("e_drain_grant", 32'(grant), 32'h2);
        send(1, 8'hE4, 1'b0, 1'b0);
        send(1, 8'hE5, 1'b0, 1'b1);
        chk("e_idle_grant", 32'(grant), 32'h0);
        repeat (2) @(posedge clk);
        #1 chk("e_err_count", 32'(err_cnt - err_start), 32'd1);

        // Two back-to-back ties: req0 first, then req1, then req0's second packet.
        push(8'hB0, 1'b1, 1'b0); push(8'hB1, 1'b0, 1'b1);
        push(8'hD0, 1'b1, 1'b0); push(8'hD1, 1'b0, 1'b1);
        push(8'hC0, 1'b1, 1'b0); push(8'hC1, 1'b0, 1'b1);
        r1_start = r1_bad;
        fork
            begin
                send(0, 8'hB0, 1'b1, 1'b0); send(0, 8'hB1, 1'b0, 1'b1);
                send(0, 8'hC0, 1'b1, 1'b0); send(0, 8'hC1, 1'b0, 1'b1);
            end
            begin
                send(1, 8'hD0, 1'b1, 1'b0); send(1, 8'hD1, 1'b0, 1'b1);
            end
        join
        chk("tie_r1_ready", 32'(r1_bad - r1_start), 32'd0);

        // Downstream stall for 4 cycles in the middle of a packet.
        push(8'hF0, 1'b1, 1'b0); push(8'hF1, 1'b0, 1'b0);
        push(8'hF2, 1'b0, 1'b0); push(8'hF3, 1'b0, 1'b1);
        fork
            begin
                send(1, 8'hF0, 1'b1, 1'b0); send(1, 8'hF1, 1'b0, 1'b0);
                send(1, 8'hF2, 1'b0, 1'b0); send(1, 8'hF3, 1'b0, 1'b1);
            end
            begin
                int m;
                m = 0;
                do begin
                    @(negedge clk);
                    m++;
                end while (!(out_valid && out_data == 8'hF1) && m < 50);
                chk("f1_seen", 32'(m < 50), 32'h1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_data", 32'(out_data), 32'hF2);
                    chk("stall_ready", 32'(req_ready[1]), 32'h0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        // Single-beat packet, then reset during req1's second beat.
        push(8'h60, 1'b1, 1'b1);
        send(0, 8'h60, 1'b1, 1'b1);
        send(1, 8'h70, 1'b1, 1'b0);
        v1 = 1'b1; h1 = 1'b0; t1 = 1'b0; d1 = 8'h71;
        reset_n = 1'b0;
        #1 chk_zero("mid_rst");
        @(posedge clk);
        #1 v1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // After reset requester 0 wins the first tie again.
        push(8'h80, 1'b1, 1'b1); push(8'h90, 1'b1, 1'b1);
        fork
            send(0, 8'h80, 1'b1, 1'b1);
            send(1, 8'h90, 1'b1, 1'b1);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        chk("err_total", 32'(err_cnt - err_start), 32'd1);
        chk("end_grant", 32'(grant), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
